rr_mux: RTL and testbench
=========================

RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter N, default 8: number of input channels, 2..16.
REQ-002 Parameter W, default 8: data width per channel, 1..32.
REQ-003 Parameter SELW, default $clog2(N): width of the channel-index signals.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset; one clock, synchronous to clk, active-high.
REQ-006 mode  input  1  0 = direct select, 1 = round-robin scan.
REQ-007 sel  input  SELW  channel index used in direct mode.
REQ-008 in_data  input  N*W  channel k occupies bits [k*W+W-1 : k*W].
REQ-009 in_valid  input  N  per-channel data-valid.
REQ-010 in_ready  output  N  per-channel accept strobe, combinational, at most one bit high.
REQ-011 out_data  output  W  registered selected data.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_chan  output  SELW  index of the channel that sourced out_data.

Function
REQ-015 Handshakes: input transfer on channel k when in_valid[k] & in_ready[k] at a rising edge; output transfer when out_valid & out_ready.
REQ-016 Output register free = !out_valid | out_ready, evaluated in the current cycle.
REQ-017 Grants occur only while the output register is free; in_ready is all-zero otherwise.
REQ-018 Direct mode: grant channel sel iff sel < N and in_valid[sel]; other channels get no grant; sel >= N grants nothing.
REQ-019 Round-robin mode: grant the first valid channel found scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-020 After a round-robin grant to channel g, ptr becomes g+1, wrapping to 0 when g = N-1, including non-power-of-two N.
REQ-021 ptr is unchanged by direct-mode grants and by cycles with no grant.
REQ-022 On a grant to channel g: out_data <= in_data[g], out_chan <= g, out_valid <= 1 at the same edge; latency is one cycle.
REQ-023 When the output register is free and no grant occurs: out_valid <= 0; out_data and out_chan hold.
REQ-024 While out_valid = 1 and out_ready = 0: out_data, out_chan and out_valid are stable.
REQ-025 Simultaneous output consume and new grant in one cycle: new word loads and out_valid stays 1, giving full throughput of one word per cycle.
REQ-026 mode and sel are sampled every cycle; a change affects the grant of that same cycle only, and an already-registered word is not altered.
REQ-027 Ordering from a single channel is preserved; no word is duplicated or dropped.

Reset
REQ-028 When rst = 1 at a rising edge: out_valid <= 0, out_data <= 0, out_chan <= 0, ptr <= 0.
REQ-029 in_ready is all-zero while rst = 1.
REQ-030 rst asserted while out_valid = 1 discards the held word; no handshake completes in that cycle.

Structure
REQ-031 Shared package mux_pkg holds MODE_DIRECT = 1'b0 and MODE_RR = 1'b1, plus the clog2 helper if the toolchain lacks $clog2.
REQ-032 Round-robin priority search is a sub-module rr_arbiter (params N, SELW; inputs req, ptr; outputs gnt_valid, gnt_idx), purely combinational.
REQ-033 rr_mux owns ptr, the output register, and the grant/ready logic.

Verification
REQ-034 Reset: rst high 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_chan = 0, in_ready = 0.
REQ-035 Direct: N=8, W=8, sel=5, in_valid=8'hFF, ch5 = 8'hA5, out_ready = 1 -> next cycle out_data = 8'hA5, out_chan = 5; in_ready = 8'h20 every cycle.
REQ-036 Round-robin fairness: mode=1, all in_valid = 1, out_ready = 1 for 10 cycles -> out_chan sequence 0,1,2,...,7,0,1.
REQ-037 Sparse/wrap: mode=1, ptr=6, in_valid = 8'b0000_0101 -> grant ch0, then ch2; ptr = 3.
REQ-038 Backpressure: out_ready = 0 for 4 cycles after a grant -> out_data stable, in_ready = 0; out_ready = 1 -> consume and next grant in the same cycle.
REQ-039 Non-power-of-two N=5, mode=1, all valid -> out_chan sequence 0,1,2,3,4,0; sel = 6 in direct mode -> no grant, out_valid drops after consume.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin multiplexer slice.
// Holds the mode encodings that rr_mux compares against its mode input.
package mux_pkg;

  // mode input encodings
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational rotating-priority search.
// Ports:
//   req       [N-1:0]    request vector, one bit per channel
//   ptr       [SELW-1:0] highest-priority channel this cycle (must be < N)
//   gnt_valid            at least one request is present
//   gnt_idx   [SELW-1:0] first requesting channel at or after ptr, wrapping at N
module rr_arbiter #(
  parameter int N    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  // One spare bit so ptr + offset never overflows before the modulo-N fold.
  localparam logic [SELW:0] N_W = (SELW+1)'(N);

  logic [SELW:0] sum_s;
  logic [SELW:0] cand_s;

  // Scan offsets from the farthest to the nearest; the nearest requester is
  // written last and therefore wins. The fold handles non-power-of-two N.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = {SELW{1'b0}};
    sum_s     = {(SELW+1){1'b0}};
    cand_s    = {(SELW+1){1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      sum_s     = {1'b0, ptr} + (SELW+1)'(i);
      cand_s    = (sum_s >= N_W) ? (sum_s - N_W) : sum_s;
      gnt_valid = gnt_valid | req[cand_s[SELW-1:0]];
      gnt_idx   = req[cand_s[SELW-1:0]] ? cand_s[SELW-1:0] : gnt_idx;
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-channel multiplexer with valid/ready handshakes and a single registered
// output stage. Channels are picked either directly by index (mode 0) or by a
// rotating round-robin scan (mode 1).
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   mode                 0 = direct select, 1 = round-robin
//   sel       [SELW-1:0] channel index used in direct mode
//   in_data   [N*W-1:0]  channel k at bits [k*W +: W]
//   in_valid  [N-1:0]    per-channel valid
//   in_ready  [N-1:0]    per-channel accept strobe (combinational, one-hot or zero)
//   out_data  [W-1:0]    registered selected word
//   out_valid            out_data holds an unconsumed word
//   out_ready            downstream accepts out_data
//   out_chan  [SELW-1:0] channel that sourced out_data
module rr_mux
  import mux_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_chan
);

  localparam logic [SELW:0]   N_W      = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

  logic [SELW-1:0] ptr_r;
  logic [W-1:0]    out_data_r;
  logic [SELW-1:0] out_chan_r;
  logic            out_valid_r;

  logic            free_s;
  logic            sel_ok_s;
  logic            arb_valid_s;
  logic [SELW-1:0] arb_idx_s;
  logic            gnt_s;
  logic            rr_gnt_s;
  logic [SELW-1:0] gnt_idx_s;
  logic [SELW-1:0] ptr_next_s;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_r),
    .gnt_valid (arb_valid_s),
    .gnt_idx   (arb_idx_s)
  );

  // Output stage can accept a word if empty or being drained this cycle.
  always_comb begin
    free_s   = ~out_valid_r | out_ready;
    sel_ok_s = ({1'b0, sel} < N_W);
  end

  // Grant selection; nothing is granted during reset or while the stage is full.
  always_comb begin
    gnt_s     = 1'b0;
    rr_gnt_s  = 1'b0;
    gnt_idx_s = {SELW{1'b0}};
    if (rst || !free_s) begin
      gnt_s = 1'b0;
    end else if (mode == MODE_RR) begin
      gnt_s     = arb_valid_s;
      rr_gnt_s  = arb_valid_s;
      gnt_idx_s = arb_idx_s;
    end else if (sel_ok_s && in_valid[sel]) begin
      gnt_s     = 1'b1;
      gnt_idx_s = sel;
    end else begin
      gnt_s = 1'b0;
    end
  end

  // Ready strobe back to the granted channel and the post-grant pointer.
  always_comb begin
    in_ready   = gnt_s ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx_s) : {N{1'b0}};
    ptr_next_s = (gnt_idx_s == LAST_IDX) ? {SELW{1'b0}} : (gnt_idx_s + SELW'(1));
  end

  // Output register and round-robin pointer. A grant in the same cycle as a
  // consume reloads the stage, so out_valid stays high at full throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_chan_r  <= {SELW{1'b0}};
      ptr_r       <= {SELW{1'b0}};
    end else if (gnt_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= in_data[gnt_idx_s*W +: W];
      out_chan_r  <= gnt_idx_s;
      ptr_r       <= rr_gnt_s ? ptr_next_s : ptr_r;
    end else if (free_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_rr_mux.sv
module tb_rr_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: N = 8
  logic        a_rst = 1'b1;
  logic        a_mode = 1'b0;
  logic [2:0]  a_sel = 3'd0;
  logic [63:0] a_in_data = 64'd0;
  logic [7:0]  a_in_valid = 8'h00;
  logic [7:0]  a_in_ready;
  logic [7:0]  a_out_data;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [2:0]  a_out_chan;

  // Instance B: N = 5 (non-power-of-two)
  logic        b_rst = 1'b1;
  logic        b_mode = 1'b0;
  logic [2:0]  b_sel = 3'd0;
  logic [39:0] b_in_data = 40'd0;
  logic [4:0]  b_in_valid = 5'h00;
  logic [4:0]  b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [2:0]  b_out_chan;

  rr_mux #(.N(8), .W(8)) dut_a (
    .clk(clk), .rst(a_rst), .mode(a_mode), .sel(a_sel),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_chan(a_out_chan)
  );

  rr_mux #(.N(5), .W(8)) dut_b (
    .clk(clk), .rst(b_rst), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_chan(b_out_chan)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle on A with fixed data pattern (channel k carries 8'hA0 | k).
  task automatic cyc_a(input logic m, input logic [2:0] s, input logic [7:0] v, input logic r,
                       input logic [7:0] e_rdy, input logic e_ov, input logic [2:0] e_ch);
    @(negedge clk);
    a_rst = 1'b0; a_mode = m; a_sel = s; a_in_valid = v; a_out_ready = r;
    #1;
    chk("a_in_ready", {24'd0, a_in_ready}, {24'd0, e_rdy});
    @(posedge clk); #1;
    chk("a_out_valid", {31'd0, a_out_valid}, {31'd0, e_ov});
    chk("a_out_chan", {29'd0, a_out_chan}, {29'd0, e_ch});
    chk("a_out_data", {24'd0, a_out_data}, {24'd0, 5'b10100, e_ch});
  endtask

  task automatic cyc_b(input logic m, input logic [2:0] s, input logic [4:0] v, input logic r,
                       input logic [4:0] e_rdy, input logic e_ov, input logic [2:0] e_ch);
    @(negedge clk);
    b_rst = 1'b0; b_mode = m; b_sel = s; b_in_valid = v; b_out_ready = r;
    #1;
    chk("b_in_ready", {27'd0, b_in_ready}, {27'd0, e_rdy});
    @(posedge clk); #1;
    chk("b_out_valid", {31'd0, b_out_valid}, {31'd0, e_ov});
    chk("b_out_chan", {29'd0, b_out_chan}, {29'd0, e_ch});
    chk("b_out_data", {24'd0, b_out_data}, {24'd0, 5'b10100, e_ch});
  endtask

  // Two reset cycles with every channel valid and the stage nominally draining.
  task automatic reset_a();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a_rst = 1'b1; a_mode = 1'b1; a_in_valid = 8'hFF; a_out_ready = 1'b1;
      #1;
      chk("a_rst_in_ready", {24'd0, a_in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("a_rst_out_valid", {31'd0, a_out_valid}, 32'd0);
      chk("a_rst_out_data", {24'd0, a_out_data}, 32'd0);
      chk("a_rst_out_chan", {29'd0, a_out_chan}, 32'd0);
    end
  endtask

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [7:0] valid;
    logic       ordy;
    logic [7:0] e_rdy;
    logic       e_ov;
    logic [2:0] e_ch;
  } vec_t;

  vec_t vecs[17];

  // Reference model state for randomized phase (instance A).
  int         m_ptr;
  logic       m_ov;
  logic [7:0] m_data;
  logic [2:0] m_chan;

  initial begin
    // Directed table, applied right after reset (ptr = 0, stage empty).
    vecs[0]  = '{1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5};
    vecs[1]  = '{1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5};
    vecs[2]  = '{1'b0, 3'd5, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd5};
    vecs[3]  = '{1'b0, 3'd5, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd5};
    vecs[4]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0};
    vecs[5]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1};
    vecs[6]  = '{1'b1, 3'd0, 8'h05, 1'b1, 8'h04, 1'b1, 3'd2};
    vecs[7]  = '{1'b1, 3'd0, 8'h05, 1'b1, 8'h01, 1'b1, 3'd0};
    vecs[8]  = '{1'b1, 3'd0, 8'h05, 1'b1, 8'h04, 1'b1, 3'd2};
    vecs[9]  = '{1'b0, 3'd3, 8'h05, 1'b1, 8'h00, 1'b0, 3'd2};
    vecs[10] = '{1'b0, 3'd3, 8'h08, 1'b0, 8'h08, 1'b1, 3'd3};
    vecs[11] = '{1'b1, 3'd0, 8'h80, 1'b1, 8'h80, 1'b1, 3'd7};
    vecs[12] = '{1'b1, 3'd0, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0};
    vecs[13] = '{1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
    vecs[14] = '{1'b1, 3'd0, 8'h03, 1'b0, 8'h02, 1'b1, 3'd1};
    vecs[15] = '{1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd1};
    vecs[16] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2};

    for (int k = 0; k < 8; k++) a_in_data[k*8 +: 8] = 8'hA0 | 8'(k);
    for (int k = 0; k < 5; k++) b_in_data[k*8 +: 8] = 8'hA0 | 8'(k);

    // Reset both instances; B reset checked alongside.
    b_in_valid = 5'h1F;
    reset_a();
    chk("b_rst_in_ready", {27'd0, b_in_ready}, 32'd0);
    chk("b_rst_out_valid", {31'd0, b_out_valid}, 32'd0);

    foreach (vecs[i])
      cyc_a(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].ordy,
            vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_ch);

    // Round-robin fairness: 10 cycles, all valid, always consuming.
    reset_a();
    for (int i = 0; i < 10; i++)
      cyc_a(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01 << (i % 8), 1'b1, 3'(i % 8));

    // Sparse/wrap: walk ptr to 6, then only ch0 and ch2 request.
    reset_a();
    for (int i = 0; i < 6; i++)
      cyc_a(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01 << i, 1'b1, 3'(i));
    cyc_a(1'b1, 3'd0, 8'h05, 1'b1, 8'h01, 1'b1, 3'd0);
    cyc_a(1'b1, 3'd0, 8'h05, 1'b1, 8'h04, 1'b1, 3'd2);
    cyc_a(1'b1, 3'd0, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3);   // ptr was 3

    // Backpressure: hold for 4 cycles, then consume and grant together.
    for (int i = 0; i < 4; i++)
      cyc_a(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3);
    cyc_a(1'b1, 3'd0, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd4);

    // Reset while holding a word discards it.
    cyc_a(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd4);
    reset_a();

    // N = 5 round-robin wrap and out-of-range direct select.
    for (int i = 0; i < 6; i++)
      cyc_b(1'b1, 3'd0, 5'h1F, 1'b1, 5'h01 << (i % 5), 1'b1, 3'(i % 5));
    cyc_b(1'b0, 3'd6, 5'h1F, 1'b1, 5'h00, 1'b0, 3'd0);
    cyc_b(1'b0, 3'd4, 5'h1F, 1'b1, 5'h10, 1'b1, 3'd4);
    cyc_b(1'b0, 3'd5, 5'h1F, 1'b1, 5'h00, 1'b0, 3'd4);

    // Randomized phase on A against a behavioural model.
    reset_a();
    m_ptr = 0; m_ov = 1'b0; m_data = 8'd0; m_chan = 3'd0;
    for (int c = 0; c < 400; c++) begin
      logic       free;
      int         g;
      logic [7:0] e_rdy;
      @(negedge clk);
      a_rst       = ($urandom_range(0, 39) == 0);
      a_mode      = 1'($urandom_range(0, 1));
      a_sel       = 3'($urandom_range(0, 7));
      a_in_valid  = 8'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_in_data   = {$urandom, $urandom};

      free = !m_ov || a_out_ready;
      g = -1;
      if (!a_rst && free) begin
        if (a_mode == 1'b0) begin
          if (a_in_valid[a_sel]) g = int'(a_sel);
        end else begin
          for (int k = 7; k >= 0; k--)
            if (a_in_valid[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
        end
      end
      e_rdy = (g >= 0) ? (8'h01 << g) : 8'h00;
      #1;
      chk("rnd_in_ready", {24'd0, a_in_ready}, {24'd0, e_rdy});

      if (a_rst) begin
        m_ov = 1'b0; m_data = 8'd0; m_chan = 3'd0; m_ptr = 0;
      end else if (g >= 0) begin
        m_ov = 1'b1; m_data = a_in_data[g*8 +: 8]; m_chan = 3'(g);
        if (a_mode == 1'b1) m_ptr = (g + 1) % 8;
      end else if (free) begin
        m_ov = 1'b0;
      end

      @(posedge clk); #1;
      chk("rnd_out_valid", {31'd0, a_out_valid}, {31'd0, m_ov});
      chk("rnd_out_chan", {29'd0, a_out_chan}, {29'd0, m_chan});
      chk("rnd_out_data", {24'd0, a_out_data}, {24'd0, m_data});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
